// File: rtl/btle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btle_pkg
// Description : Shared types and constants for the BLE transmit bit framer.
//               Holds the framer FSM encoding, the default preamble length,
//               the PDU octet-count width and the two 8-bit preamble patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package btle_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_ACCESS   = 2'd2,
        S_PDU      = 2'd3
    } state_t;

    localparam int c_LEN_PREAMBLE_DEFAULT = 8;
    localparam int c_PDU_OCTET_CNT_W      = 9;

    // Preamble patterns (LSB sent first), chosen so that the final preamble
    // bit differs from access-address bit 0.
    localparam logic [7:0] c_PREAMBLE_AA0_1 = 8'h55;
    localparam logic [7:0] c_PREAMBLE_AA0_0 = 8'hAA;

endpackage
`default_nettype wire

// File: rtl/btle_tx_bit_framer_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_period_timer
// Description : Bit-period divider. While i_enable is high the counter runs
//               down from CLK_PER_BIT-1 and o_tick fires when it reaches 0.
//               The counter is parked at 0 while disabled, so the first
//               enabled cycle is itself a tick. o_last marks the final clock
//               of each bit period.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_enable      - run the divider
//               o_tick        - first clock of a bit period
//               o_last        - last clock of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module bit_period_timer #(
    parameter int CLK_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_tick,
    output logic o_last
);

    localparam int c_CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_LOAD = c_CW'(CLK_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !i_enable) begin
            r_cnt <= '0;
        end else if (r_cnt == '0) begin
            r_cnt <= c_LOAD;
        end else begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_tick = i_enable & (r_cnt == '0);
    assign o_last = i_enable & (r_cnt == c_ONE);

endmodule
`default_nettype wire

// File: rtl/btle_tx_bit_framer.sv
`default_nettype none
// ============================================================================
// Module      : btle_tx_bit_framer
// Description : BLE transmit bit framer. On an accepted start it serializes
//               preamble, access address and N PDU octets, LSB first, one
//               bit per CLK_PER_BIT clocks. PDU octets are fetched over a
//               valid/ready byte interface into a one-byte holding register.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               start                  - frame request (honoured in IDLE)
//               unique_bit_sequence    - access address, sampled on start
//               num_pdu_octet          - PDU octet count, sampled on start
//               pdu_octet/_valid/_ready- PDU byte stream
//               phy_bit, bit_valid     - air bit and per-period strobe
//               busy, done, underrun   - frame status
// Revision    : 1.0 - initial release
// ============================================================================
module btle_tx_bit_framer
    import btle_pkg::*;
#(
    parameter int LEN_UNIQUE_BIT_SEQUENCE = 32,
    parameter int LEN_PREAMBLE            = c_LEN_PREAMBLE_DEFAULT,
    parameter int CLK_PER_BIT             = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] unique_bit_sequence,
    input  logic [c_PDU_OCTET_CNT_W-1:0]       num_pdu_octet,
    input  logic [7:0]                         pdu_octet,
    input  logic                               pdu_octet_valid,
    output logic                               pdu_octet_ready,
    output logic                               phy_bit,
    output logic                               bit_valid,
    output logic                               busy,
    output logic                               done,
    output logic                               underrun
);

    localparam int c_FIELD_MAX = (LEN_UNIQUE_BIT_SEQUENCE > LEN_PREAMBLE) ?
                                 LEN_UNIQUE_BIT_SEQUENCE : LEN_PREAMBLE;
    localparam int c_BCW = $clog2(c_FIELD_MAX);
    localparam logic [c_BCW-1:0] c_PRE_LAST = c_BCW'(LEN_PREAMBLE - 1);
    localparam logic [c_BCW-1:0] c_AA_LAST  = c_BCW'(LEN_UNIQUE_BIT_SEQUENCE - 1);
    localparam logic [c_BCW-1:0] c_OCT_LAST = c_BCW'(7);
    localparam logic [c_BCW-1:0] c_BIT_ONE  = c_BCW'(1);
    localparam logic [c_PDU_OCTET_CNT_W-1:0] c_OCT_ONE = c_PDU_OCTET_CNT_W'(1);

    state_t                               r_state;
    state_t                               w_state_next;
    logic   [c_BCW-1:0]                   r_bit_cnt;
    logic   [c_PDU_OCTET_CNT_W-1:0]       r_octet_cnt;
    logic   [c_PDU_OCTET_CNT_W-1:0]       r_num_octet;
    logic   [c_PDU_OCTET_CNT_W-1:0]       r_fetch_cnt;
    logic   [LEN_UNIQUE_BIT_SEQUENCE-1:0] r_aa;
    logic   [7:0]                         r_pre;
    logic   [7:0]                         r_shift;
    logic   [7:0]                         r_hold;
    logic                                 r_hold_full;
    logic                                 r_done;

    logic w_tick;
    logic w_last;
    logic w_accept;
    logic w_xfer;
    logic w_octet_start;
    logic w_last_octet;
    logic w_frame_end;

    assign busy            = (r_state != S_IDLE);
    assign bit_valid       = w_tick;
    assign done            = r_done;
    // A start coinciding with the done pulse is dropped.
    assign w_accept        = (r_state == S_IDLE) & start & ~r_done;
    // Ready depends only on registered state, never on pdu_octet_valid.
    assign pdu_octet_ready = busy & ~r_hold_full & (r_fetch_cnt < r_num_octet);
    assign w_xfer          = pdu_octet_ready & pdu_octet_valid;
    assign w_octet_start   = w_tick & (r_state == S_PDU) & (r_bit_cnt == '0);
    assign w_last_octet    = ((r_octet_cnt + c_OCT_ONE) == r_num_octet);

    bit_period_timer #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_enable (busy),
        .o_tick   (w_tick),
        .o_last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        phy_bit      = 1'b0;
        underrun     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                phy_bit = r_pre[0];
                if (w_last && (r_bit_cnt == c_PRE_LAST)) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                phy_bit = r_aa[0];
                if (w_last && (r_bit_cnt == c_AA_LAST)) begin
                    if (r_num_octet == '0) begin
                        w_state_next = S_IDLE;
                        w_frame_end  = 1'b1;
                    end else begin
                        w_state_next = S_PDU;
                    end
                end
            end
            S_PDU: begin
                // In the first clock of an octet the shifter is not yet
                // loaded, so the bit comes straight from the hold register
                // (or is zero when nothing was held).
                if (w_octet_start) begin
                    phy_bit  = r_hold_full & r_hold[0];
                    underrun = ~r_hold_full;
                end else begin
                    phy_bit = r_shift[0];
                end
                if (w_last && (r_bit_cnt == c_OCT_LAST) && w_last_octet) begin
                    w_state_next = S_IDLE;
                    w_frame_end  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Bit sequencing: fields advance at the last clock of each bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done      <= 1'b0;
            r_aa        <= '0;
            r_pre       <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_octet_cnt <= '0;
            r_num_octet <= '0;
        end else begin
            r_done <= w_frame_end;
            if (w_accept) begin
                r_aa        <= unique_bit_sequence;
                r_pre       <= unique_bit_sequence[0] ? c_PREAMBLE_AA0_1 : c_PREAMBLE_AA0_0;
                r_num_octet <= num_pdu_octet;
                r_bit_cnt   <= '0;
                r_octet_cnt <= '0;
            end else if (w_last) begin
                case (r_state)
                    S_PREAMBLE: begin
                        // Rotating the alternating pattern covers any even length.
                        r_pre     <= {r_pre[0], r_pre[7:1]};
                        r_bit_cnt <= (r_bit_cnt == c_PRE_LAST) ? '0 : r_bit_cnt + c_BIT_ONE;
                    end
                    S_ACCESS: begin
                        r_aa      <= r_aa >> 1;
                        r_bit_cnt <= (r_bit_cnt == c_AA_LAST) ? '0 : r_bit_cnt + c_BIT_ONE;
                    end
                    S_PDU: begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == c_OCT_LAST) begin
                            r_bit_cnt   <= '0;
                            r_octet_cnt <= r_octet_cnt + c_OCT_ONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (w_octet_start) begin
                r_shift <= r_hold_full ? r_hold : 8'h00;
            end
        end
    end

    // Octet fetch: one holding byte, refilled whenever empty and more octets
    // remain. An arrival in the octet-start cycle itself lands in the hold
    // and feeds the following octet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_fetch_cnt <= '0;
        end else if (w_accept) begin
            r_hold_full <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            if (w_octet_start) begin
                r_hold_full <= 1'b0;
            end
            if (w_xfer) begin
                r_hold      <= pdu_octet;
                r_hold_full <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + c_OCT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btle_tx_bit_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_btle_tx_bit_framer
// Description : Directed self-checking bench for btle_tx_bit_framer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btle_tx_bit_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] unique_bit_sequence;
    logic [8:0]  num_pdu_octet;
    logic [7:0]  pdu_octet;
    logic        pdu_octet_valid;
    logic        pdu_octet_ready;
    logic        phy_bit;
    logic        bit_valid;
    logic        busy;
    logic        done;
    logic        underrun;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]   tx_bytes[$];
    logic [7:0]   exp_bytes[$];
    logic [599:0] cap;

    always #5 clk = ~clk;

    btle_tx_bit_framer #(
        .LEN_UNIQUE_BIT_SEQUENCE (32),
        .LEN_PREAMBLE            (8),
        .CLK_PER_BIT             (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .unique_bit_sequence (unique_bit_sequence),
        .num_pdu_octet       (num_pdu_octet),
        .pdu_octet           (pdu_octet),
        .pdu_octet_valid     (pdu_octet_valid),
        .pdu_octet_ready     (pdu_octet_ready),
        .phy_bit             (phy_bit),
        .bit_valid           (bit_valid),
        .busy                (busy),
        .done                (done),
        .underrun            (underrun)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle: pulses start for one cycle and
    // captures the whole frame, feeding tx_bytes as ready allows.
    task automatic run_frame(input logic [31:0] aa, input int n, input logic [7:0] exp_pre,
                             input int withhold, input int exp_ur_cnt, input int exp_ur_idx,
                             input bit inj_busy_start, input bit inj_done_start);
        int nb = 0, idx = 0, last_k = 0, first_k = 0, done_k = 0;
        int spacing_err = 0, stab_err = 0, ur_cnt = 0, ur_idx = -1, ready_seen = 0;
        int hits = 0, hit_idx = -1, post_strobes = 0, post_busy = 0, post_done = 0;
        logic busy_at_done = 1'b1, phy_at_done = 1'b1, cur_phy = 1'b0;
        bit got_done = 0;
        cap = '0;
        unique_bit_sequence = aa;
        num_pdu_octet = 9'(n);
        start = 1'b1;
        for (int k = 1; k <= 2000 && !got_done; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (inj_busy_start && k == 100) start = 1'b1;
            if (bit_valid) begin
                if (nb == 0) first_k = k;
                else if (k - last_k != 8) spacing_err++;
                cap[nb] = phy_bit;
                cur_phy = phy_bit;
                last_k  = k;
                nb++;
            end else if (busy && phy_bit !== cur_phy) begin
                stab_err++;
            end
            if (underrun) begin ur_cnt++; ur_idx = nb - 1; end
            if (pdu_octet_ready) ready_seen++;
            if (done) begin
                got_done = 1;
                done_k = k;
                busy_at_done = busy;
                phy_at_done = phy_bit;
                if (inj_done_start) start = 1'b1;
            end
            pdu_octet_valid = 1'b0;
            if (idx < tx_bytes.size() && !(idx == withhold && nb <= 40 + 8 * withhold)) begin
                pdu_octet = tx_bytes[idx];
                pdu_octet_valid = 1'b1;
                if (pdu_octet_ready) idx++;
            end
        end
        pdu_octet_valid = 1'b0;
        check("done_seen", 64'(got_done), 64'd1);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (bit_valid) post_strobes++;
            if (busy) post_busy++;
            if (done) post_done++;
        end
        check("n_strobes", nb, 40 + 8 * n);
        check("first_strobe", first_k, 1);
        check("spacing_err", spacing_err, 0);
        check("phy_stable_err", stab_err, 0);
        check("preamble", cap[7:0], exp_pre);
        check("access_addr", cap[39:8], aa);
        for (int o = 0; o < n; o++) check($sformatf("pdu_octet%0d", o), cap[40 + 8 * o +: 8], exp_bytes[o]);
        check("done_offset", done_k - last_k, 8);
        check("busy_at_done", busy_at_done, 1'b0);
        check("phy_at_done", phy_at_done, 1'b0);
        check("underrun_cnt", ur_cnt, exp_ur_cnt);
        check("underrun_idx", ur_idx, exp_ur_idx);
        check("ready_seen", 64'(ready_seen != 0), 64'(n != 0));
        for (int i = 31; i < nb; i++) begin
            if (cap[i - 31 +: 32] == aa) begin hits++; hit_idx = i; end
        end
        check("aa_search_hits", hits, 1);
        check("aa_search_idx", hit_idx, 39);
        check("post_strobes", post_strobes, 0);
        check("post_busy", post_busy, 0);
        check("post_done", post_done, 0);
    endtask

    initial begin
        int nb;
        bit saw_done;
        rst = 1'b1; start = 1'b0; unique_bit_sequence = '0; num_pdu_octet = '0;
        pdu_octet = '0; pdu_octet_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {pdu_octet_ready, phy_bit, bit_valid, busy, done, underrun}, 6'b0);
        start = 1'b1;
        @(negedge clk);
        check("reset_blocks_start", {busy, bit_valid}, 2'b00);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame with ignored starts mid-frame and in the done cycle.
        tx_bytes = '{8'h01, 8'hA5};
        exp_bytes = '{8'h01, 8'hA5};
        run_frame(32'h8E89BED6, 2, 8'hAA, -1, 0, -1, 1'b1, 1'b1);

        // Empty PDU.
        tx_bytes = {};
        exp_bytes = {};
        run_frame(32'h00000001, 0, 8'h55, -1, 0, -1, 1'b0, 1'b0);

        // Octet 1 withheld past its first bit: zeros sent, later byte fills octet 2.
        tx_bytes = '{8'h3C, 8'h96};
        exp_bytes = '{8'h3C, 8'h00, 8'h96};
        run_frame(32'h8E89BED6, 3, 8'hAA, 1, 1, 48, 1'b0, 1'b0);

        // Reset mid-frame at bit 20.
        unique_bit_sequence = 32'h8E89BED6;
        num_pdu_octet = 9'd2;
        start = 1'b1;
        nb = 0;
        saw_done = 0;
        for (int k = 0; k < 400 && nb < 21; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (bit_valid) nb++;
            if (done) saw_done = 1;
        end
        check("reached_bit20", nb, 21);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs", {pdu_octet_ready, phy_bit, bit_valid, busy, done, underrun}, 6'b0);
        check("rst_no_done", 64'(saw_done), 64'd0);
        rst = 1'b0;
        tx_bytes = '{8'hC3};
        exp_bytes = '{8'hC3};
        run_frame(32'hA5A5F00F, 1, 8'h55, -1, 0, -1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
